instr_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute/writeback controller for the GPR/SGPR datapath.

---
 rtl/instr_sequencer.sv | 131 +++++++++++++
 tb/tb_instr_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_sequencer : multi-cycle fetch/decode/execute/writeback controller
// Rev 1.0
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PC_W    = 8,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ir,
  output logic            exec_en,
  output logic            gpr_we,
  output logic            sgpr_we,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  localparam int         CNT_W     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [4:0] C_OP_MUL  = 5'd4;
  localparam logic [4:0] C_OP_HALT = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       w_op;
  logic             w_is_mul;
  logic             w_is_alu;

  assign w_op      = ir[31:27];
  assign w_is_mul  = (w_op == C_OP_MUL);
  // Opcodes 0..4 are the legal datapath operations.
  assign w_is_alu  = (w_op <= C_OP_MUL);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    exec_en  = 1'b0;
    gpr_we   = 1'b0;
    sgpr_we  = 1'b0;
    busy     = 1'b1;
    halted   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_alu) w_next = S_EXEC;
        else          w_next = S_HALT;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        if (r_cnt == '0) w_next = S_WB;
      end
      S_WB: begin
        gpr_we  = 1'b1;
        sgpr_we = w_is_mul;
        w_next  = S_FETCH;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      r_cnt   <= '0;
      illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc      <= '0;
            illegal <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem_ack) ir <= imem_rdata;
        end
        S_DECODE: begin
          if (w_op == C_OP_HALT) illegal <= 1'b0;
          else if (!w_is_alu)    illegal <= 1'b1;
          else                   r_cnt   <= w_is_mul ? CNT_W'(MUL_LAT - 1) : '0;
        end
        S_EXEC: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_WB: begin
          pc <= pc + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_sequencer : scoreboard bench for instr_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int PC_W    = 2;
  localparam int MUL_LAT = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = 32'h0;
  logic [31:0]     ir;
  logic            exec_en;
  logic            gpr_we;
  logic            sgpr_we;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            illegal;

  instr_sequencer #(.PC_W(PC_W), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .exec_en    (exec_en),
    .gpr_we     (gpr_we),
    .sgpr_we    (sgpr_we),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] MOV1  = {5'd1, 5'd1, 22'd5};
  localparam logic [31:0] MUL2  = {5'd4, 5'd2, 5'd1, 5'd1, 12'd0};
  localparam logic [31:0] ADD3  = {5'd2, 5'd3, 5'd1, 5'd2, 12'd0};
  localparam logic [31:0] SUB4  = {5'd3, 5'd4, 5'd3, 5'd1, 12'd0};
  localparam logic [31:0] ILL7  = {5'd7, 27'h0000123};
  localparam logic [31:0] HALTW = {5'd31, 27'd0};

  typedef struct {
    bit            is_halt;
    bit [PC_W-1:0] pc;
    bit [31:0]     ir;
    bit            sgpr;
    int            execs;
    bit            ill;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mem[4];
  int          dly[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ret(input bit [PC_W-1:0] p, input bit [31:0] w, input bit s, input int n);
    exp_t e;
    e = '{is_halt: 1'b0, pc: p, ir: w, sgpr: s, execs: n, ill: 1'b0};
    sb.push_back(e);
  endtask

  task automatic push_halt(input bit [PC_W-1:0] p, input bit [31:0] w, input bit il);
    exp_t e;
    e = '{is_halt: 1'b1, pc: p, ir: w, sgpr: 1'b0, execs: 0, ill: il};
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_halt(input int max_cyc);
    for (int i = 0; i < max_cyc && !halted; i++) begin
      @(posedge clk);
      #1;
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  // Memory model: per-address ack delay, junk data and stray acks when idle.
  initial begin : responder
    int              wc;
    logic [PC_W-1:0] held;
    wc   = 0;
    held = '0;
    forever begin
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      if (!rst_n) begin
        wc = 0;
      end else if (imem_req) begin
        if (wc == 0) held = imem_addr;
        else         chk("req_addr_stable", imem_addr, held);
        if (wc >= dly[imem_addr]) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          wc         = 0;
        end else begin
          wc++;
        end
      end else begin
        if (wc != 0) chk("req_held", imem_req, 1'b1);
        wc       = 0;
        imem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin : monitor
    int   ex;
    logic prev_h;
    exp_t e;
    ex     = 0;
    prev_h = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ex     = 0;
        prev_h = 1'b0;
      end else begin
        if (exec_en) ex++;
        if (sgpr_we && !gpr_we) chk("sgpr_alone", {sgpr_we, gpr_we}, 2'b11);
        if (gpr_we) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_gpr_we: pc=%0d ir=%h expected no write", pc, ir);
          end else begin
            e = sb.pop_front();
            chk("ret_not_halt", e.is_halt, 1'b0);
            chk("ret_pc", pc, e.pc);
            chk("ret_ir", ir, e.ir);
            chk("ret_sgpr_we", sgpr_we, e.sgpr);
            chk("ret_exec_cycles", ex, e.execs);
          end
          ex = 0;
        end
        if (halted && !prev_h) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_halt: pc=%0d ir=%h expected running", pc, ir);
          end else begin
            e = sb.pop_front();
            chk("halt_expected", e.is_halt, 1'b1);
            chk("halt_pc", pc, e.pc);
            chk("halt_ir", ir, e.ir);
            chk("halt_illegal", illegal, e.ill);
            chk("halt_busy", busy, 1'b0);
            chk("halt_no_exec", ex, 0);
          end
        end
        prev_h = halted;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    for (int i = 0; i < 4; i++) begin
      mem[i] = 32'h0;
      dly[i] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {imem_req, imem_addr, ir, exec_en, gpr_we, sgpr_we, pc, busy, halted, illegal}, 64'h0);

    // Program A: mov, mul, add with slow fetch, halt at pc=3.
    mem[0] = MOV1; mem[1] = MUL2; mem[2] = ADD3; mem[3] = HALTW;
    dly[2] = 5;
    push_ret(2'd0, MOV1, 1'b0, 1);
    push_ret(2'd1, MUL2, 1'b1, MUL_LAT);
    push_ret(2'd2, ADD3, 1'b0, 1);
    push_halt(2'd3, HALTW, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    chk("fetch_after_start", {busy, imem_req, imem_addr}, {1'b1, 1'b1, 2'd0});
    @(posedge clk); #1 chk("ir_at_edge2", ir, MOV1);
    @(posedge clk); #1 chk("exec_at_edge3", exec_en, 1'b1);
    @(posedge clk); #1 chk("wb_at_edge4", {gpr_we, sgpr_we, pc}, {1'b1, 1'b0, 2'd0});
    @(posedge clk); #1 chk("pc_after_wb", pc, 2'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_halt(200);
    repeat (3) @(posedge clk);
    #1 chk("halt_hold", {pc, ir, busy, halted}, {2'd3, HALTW, 1'b0, 1'b1});

    // Program B: illegal opcode after one retirement.
    dly[2] = 0;
    mem[1] = ILL7;
    push_ret(2'd0, MOV1, 1'b0, 1);
    push_halt(2'd1, ILL7, 1'b1);
    pulse_start();
    chk("restart_from_halt", {pc, illegal, imem_req, halted}, {2'd0, 1'b0, 1'b1, 1'b0});
    wait_halt(100);
    chk("illegal_sticky", {illegal, pc}, {1'b1, 2'd1});

    // Program C: reset lands in the second mul execute cycle.
    mem[0] = MUL2;
    pulse_start();
    chk("restart_clears_illegal", {pc, illegal, imem_req}, {2'd0, 1'b0, 1'b1});
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(posedge clk);
      #1;
      if (exec_en) n++;
    end
    chk("reached_mul_exec2", n, 2);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {imem_req, imem_addr, ir, exec_en, gpr_we, sgpr_we, pc, busy, halted, illegal}, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Program D: four instructions, pc wraps 3 -> 0 and then halts.
    mem[0] = MOV1; mem[1] = ADD3; mem[2] = SUB4; mem[3] = MUL2;
    push_ret(2'd0, MOV1, 1'b0, 1);
    push_ret(2'd1, ADD3, 1'b0, 1);
    push_ret(2'd2, SUB4, 1'b0, 1);
    push_ret(2'd3, MUL2, 1'b1, MUL_LAT);
    push_halt(2'd0, HALTW, 1'b0);
    pulse_start();
    for (int i = 0; i < 100 && pc != 2'd3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_pc3", pc, 2'd3);
    mem[0] = HALTW;
    wait_halt(100);
    chk("wrap_pc", pc, 2'd0);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
